pc_gen: RTL and testbench

// Parametrised fetch PC generator at the head of the IF stage. Holds the

---
 rtl/pc_gen_if.sv | 35 +++
 rtl/pc_gen.sv | 121 ++++++++++++
 tb/tb_pc_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch PC generator bus: control inputs from fetch/EX/exception logic and
// the registered PC/queue status returned by pc_gen.
//   fetch_ready      : current pc accepted by fetch this cycle
//   branch_valid     : branch redirect request, target in branch_target
//   flush_valid      : flush/exception redirect, vector in flush_target
//   pc               : current fetch address
//   redirect_pending : branch redirect queue non-empty
//   pending_count    : number of queued branch redirects
//   redirect_ovf     : sticky flag, a branch was dropped on a full queue
interface pc_gen_if #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REDIR_DEPTH = 2
);
  localparam int unsigned CNT_W = $clog2(REDIR_DEPTH + 1);

  logic              fetch_ready;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              flush_valid;
  logic [ADDR_W-1:0] flush_target;
  logic [ADDR_W-1:0] pc;
  logic              redirect_pending;
  logic [CNT_W-1:0]  pending_count;
  logic              redirect_ovf;

  modport master (
    output fetch_ready, branch_valid, branch_target, flush_valid, flush_target,
    input  pc, redirect_pending, pending_count, redirect_ovf
  );

  modport slave (
    input  fetch_ready, branch_valid, branch_target, flush_valid, flush_target,
    output pc, redirect_pending, pending_count, redirect_ovf
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator at the head of the IF stage. Advances pc by FETCH_BYTES
// per accepted fetch, applies queued branch redirects after DELAY_SLOTS
// sequential fetches, and applies flush redirects on the next edge.
//   clk : clock
//   rst : asynchronous reset, active-low
//   bus : pc_gen_if.slave (control inputs, registered pc/status outputs)
module pc_gen #(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hbfc00000,
  parameter int unsigned FETCH_BYTES  = 4,
  parameter int unsigned DELAY_SLOTS  = 1,
  parameter int unsigned REDIR_DEPTH  = 2
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);
  localparam int unsigned CNT_W  = $clog2(REDIR_DEPTH + 1);
  localparam int unsigned PTR_W  = (REDIR_DEPTH > 1) ? $clog2(REDIR_DEPTH) : 1;
  localparam int unsigned SLOT_W = 2;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] tgt_q   [REDIR_DEPTH];
  logic [ADDR_W-1:0] tgt_d   [REDIR_DEPTH];
  logic [SLOT_W-1:0] slots_q [REDIR_DEPTH];
  logic [SLOT_W-1:0] slots_d [REDIR_DEPTH];
  logic              push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REDIR_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: flush wins, otherwise advance/pop then enqueue.
  always_comb begin
    pc_d    = pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    tgt_d   = tgt_q;
    slots_d = slots_q;
    push    = 1'b0;
    pop     = 1'b0;

    if (bus.flush_valid) begin
      pc_d  = bus.flush_target;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (bus.fetch_ready) begin
        if (cnt_q == '0) begin
          pc_d = pc_q + ADDR_W'(FETCH_BYTES);
        end else if (slots_q[rd_q] != '0) begin
          pc_d           = pc_q + ADDR_W'(FETCH_BYTES);
          slots_d[rd_q]  = slots_q[rd_q] - SLOT_W'(1);
        end else begin
          pc_d = tgt_q[rd_q];
          pop  = 1'b1;
        end
      end

      // A pop in the same edge frees a slot, so a full queue still accepts.
      if (bus.branch_valid) begin
        if ((cnt_q < CNT_W'(REDIR_DEPTH)) || pop) begin
          push = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end

      // When full, wr == rd: the popped head's target was already consumed above.
      if (push) begin
        tgt_d[wr_q]   = bus.branch_target;
        slots_d[wr_q] = SLOT_W'(DELAY_SLOTS);
        wr_d          = ptr_inc(wr_q);
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    pend_d = (cnt_d != '0);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_VECTOR;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      for (int i = 0; i < int'(REDIR_DEPTH); i++) begin
        tgt_q[i]   <= '0;
        slots_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      tgt_q   <= tgt_d;
      slots_q <= slots_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pending_count    = cnt_q;
  assign bus.redirect_pending = pend_q;
  assign bus.redirect_ovf     = ovf_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: queue-based reference model checked every cycle, plus
// directed vectors with hand-computed pc/count/ovf expectations.
module tb_pc_gen;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DSLOTS = 1;
  localparam logic [31:0] RVEC   = 32'hbfc00000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen_if #(.ADDR_W(ADDR_W), .REDIR_DEPTH(DEPTH)) bus ();

  pc_gen #(
    .ADDR_W(ADDR_W), .RESET_VECTOR(RVEC), .FETCH_BYTES(4),
    .DELAY_SLOTS(DSLOTS), .REDIR_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pc plus a list of {target, remaining slots}.
  typedef struct {
    logic [31:0] t;
    int          s;
  } ent_t;

  logic [31:0] m_pc;
  ent_t        mq[$];
  bit          m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc  = RVEC;
      mq.delete();
      m_ovf = 1'b0;
    end else if (bus.flush_valid) begin
      m_pc  = bus.flush_target;
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (bus.fetch_ready) begin
        if (mq.size() == 0) begin
          m_pc = m_pc + 32'd4;
        end else if (mq[0].s > 0) begin
          m_pc = m_pc + 32'd4;
          mq[0].s = mq[0].s - 1;
        end else begin
          m_pc = mq[0].t;
          void'(mq.pop_front());
        end
      end
      if (bus.branch_valid) begin
        if (mq.size() < int'(DEPTH)) mq.push_back('{t: bus.branch_target, s: int'(DSLOTS)});
        else m_ovf = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("model_pc", bus.pc, m_pc);
      chk("model_cnt", 32'(bus.pending_count), 32'(mq.size()));
      chk("model_pend", 32'(bus.redirect_pending), 32'(mq.size() != 0));
      chk("model_ovf", 32'(bus.redirect_ovf), 32'(m_ovf));
    end
  end

  task automatic step(input bit rdy, input bit bv = 1'b0, input logic [31:0] bt = '0,
                      input bit fv = 1'b0, input logic [31:0] ft = '0);
    bus.fetch_ready   = rdy;
    bus.branch_valid  = bv;
    bus.branch_target = bt;
    bus.flush_valid   = fv;
    bus.flush_target  = ft;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.fetch_ready   = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus.flush_valid   = 1'b0;
    bus.flush_target  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", bus.pc, 32'hbfc00000);
    chk("rst_cnt", 32'(bus.pending_count), 32'd0);
    chk("rst_ovf", 32'(bus.redirect_ovf), 32'd0);
    rst = 1'b1;

    // Sequential fetch.
    step(1); chk("seq0", bus.pc, 32'hbfc00004);
    step(1); chk("seq1", bus.pc, 32'hbfc00008);
    step(1); chk("seq2", bus.pc, 32'hbfc0000c);

    // Stall: pc moves only on ready edges.
    step(1); chk("tog1", bus.pc, 32'hbfc00010);
    step(0); chk("tog0a", bus.pc, 32'hbfc00010);
    step(0); chk("tog0b", bus.pc, 32'hbfc00010);
    step(1); chk("tog1b", bus.pc, 32'hbfc00014);

    // One branch, one delay slot.
    step(0, 1, 32'h80000000);
    chk("br_cnt", 32'(bus.pending_count), 32'd1);
    chk("br_pend", 32'(bus.redirect_pending), 32'd1);
    step(1); chk("br_slot", bus.pc, 32'hbfc00018);
    step(1); chk("br_tgt", bus.pc, 32'h80000000);
    chk("br_cnt0", 32'(bus.pending_count), 32'd0);
    step(1); chk("br_after", bus.pc, 32'h80000004);

    // Two queued branches A=0x100, B=0x200.
    step(0, 1, 32'h100);
    step(0, 1, 32'h200);
    chk("ab_cnt2", 32'(bus.pending_count), 32'd2);
    step(1); chk("ab_pc0", bus.pc, 32'h80000008);
    chk("ab_c0", 32'(bus.pending_count), 32'd2);
    step(1); chk("ab_pcA", bus.pc, 32'h100);
    chk("ab_c1", 32'(bus.pending_count), 32'd1);
    step(1); chk("ab_pcA4", bus.pc, 32'h104);
    chk("ab_c2", 32'(bus.pending_count), 32'd1);
    step(1); chk("ab_pcB", bus.pc, 32'h200);
    chk("ab_c3", 32'(bus.pending_count), 32'd0);

    // Overflow on full queue, then push accepted alongside a pop.
    step(0, 1, 32'h300);
    step(0, 1, 32'h400);
    step(0, 1, 32'h500);
    chk("ovf_set", 32'(bus.redirect_ovf), 32'd1);
    chk("ovf_cnt", 32'(bus.pending_count), 32'd2);
    step(1); chk("ovf_slot", bus.pc, 32'h204);
    step(1, 1, 32'h600);
    chk("full_pop_pc", bus.pc, 32'h300);
    chk("full_pop_cnt", 32'(bus.pending_count), 32'd2);
    chk("ovf_sticky", 32'(bus.redirect_ovf), 32'd1);

    // Flush beats the same-cycle branch and clears everything.
    step(0, 1, 32'h700, 1, 32'hbfc00380);
    chk("fl_pc", bus.pc, 32'hbfc00380);
    chk("fl_cnt", 32'(bus.pending_count), 32'd0);
    chk("fl_ovf", 32'(bus.redirect_ovf), 32'd0);

    // Address wrap.
    step(0, 0, '0, 1, 32'hfffffffc);
    step(1); chk("wrap", bus.pc, 32'h00000000);

    // Async reset with a redirect queued.
    step(0, 1, 32'h800);
    chk("pre_rst_cnt", 32'(bus.pending_count), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pc", bus.pc, 32'hbfc00000);
    chk("arst_cnt", 32'(bus.pending_count), 32'd0);
    chk("arst_pend", 32'(bus.redirect_pending), 32'd0);
    bus.branch_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1); chk("post_rst", bus.pc, 32'hbfc00004);
    step(1); chk("post_rst2", bus.pc, 32'hbfc00008);
    chk("post_rst_cnt", 32'(bus.pending_count), 32'd0);

    step(0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
